// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel frame receiver.
package s2p_pkg;

   typedef enum logic [1:0] {
      S2P_IDLE = 2'd0,
      S2P_RECV = 2'd1,
      S2P_PAR  = 2'd2
   } s2p_state_t;

   localparam int unsigned S2P_N_DEFAULT = 16;

endpackage

// File: rtl/shiftreg_s2p.sv
// N-bit right-shift register: new bits enter at the MSB, so an LSB-first frame ends up in natural order.
module shiftreg_s2p #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         shift_en,
   input  logic         din,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (shift_en)
         q <= {din, q[N-1:1]};
   end

endmodule

// File: rtl/serial_s2p_rx.sv
// Serial-to-parallel frame receiver with double-buffered ready/valid output.
// Optional even-parity bit after the data word is enabled by defining S2P_PARITY_EN.
module serial_s2p_rx
   import s2p_pkg::*;
#(
   parameter int unsigned N     = S2P_N_DEFAULT,
   parameter int unsigned CNT_W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sin,
   output logic [N-1:0] pout,
   output logic         pvalid,
   input  logic         pready,
   output logic         busy,
   output logic         overrun,
   input  logic         clr_ovr,
   output logic         parity_err
);

   s2p_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N-1:0]     sreg;
   logic [N-1:0]     commit_word;
   logic             shift_en;
   logic             commit;
   logic             drop;

   shiftreg_s2p #(.N(N)) u_sreg (
      .clk      (clk),
      .clr      (!rst),
      .shift_en (shift_en),
      .din      (sin),
      .q        (sreg)
   );

`ifdef S2P_PARITY_EN
   logic par_chk;

   // Word is fully shifted in by the time the parity bit arrives.
   assign commit_word = sreg;
`else
   logic unused_lsb;

   // Word commits on the same cycle its last bit arrives, bypassing the shift register.
   assign commit_word = {sin, sreg[N-1:1]};
   assign unused_lsb  = sreg[0];
`endif

   // Next-state and datapath control
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_en  = 1'b0;
      commit    = 1'b0;
`ifdef S2P_PARITY_EN
      par_chk   = 1'b0;
`endif
      case (state)
         S2P_IDLE: begin
            if (start) begin
               shift_en  = 1'b1;
               cnt_nxt   = CNT_W'(1);
               state_nxt = S2P_RECV;
            end
         end
         S2P_RECV: begin
            shift_en = 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
               cnt_nxt = '0;
`ifdef S2P_PARITY_EN
               state_nxt = S2P_PAR;
`else
               state_nxt = S2P_IDLE;
               commit    = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`ifdef S2P_PARITY_EN
         S2P_PAR: begin
            state_nxt = S2P_IDLE;
            commit    = 1'b1;
            par_chk   = 1'b1;
         end
`endif
         default: begin
            state_nxt = S2P_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign drop = commit && pvalid && !pready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S2P_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt != S2P_IDLE);
      end
   end

   // Holding register: a full, unaccepted buffer drops the new word and flags overrun.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pout    <= '0;
         pvalid  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (commit) begin
            if (!drop) begin
               pout   <= commit_word;
               pvalid <= 1'b1;
            end
         end else if (pvalid && pready) begin
            pvalid <= 1'b0;
         end

         if (drop)
            overrun <= 1'b1;
         else if (clr_ovr)
            overrun <= 1'b0;
      end
   end

`ifdef S2P_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst)
         parity_err <= 1'b0;
      else if (par_chk && ((^sreg) ^ sin))
         parity_err <= 1'b1;
      else if (clr_ovr)
         parity_err <= 1'b0;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
